// File: rtl/uart_boot_loader.sv
// uart_boot_loader: polls the UART for a framed program image, writes it into IMEM and replies ACK/NAK.
// Bytes are fetched as status-poll/read pairs; the CPU is held for the whole session.
module uart_boot_loader #(
  parameter int         IMEM_AW     = 10,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               uart_cs,
  output logic               uart_ren,
  output logic               uart_wen,
  output logic [11:0]        uart_addr,
  output logic [31:0]        uart_wdata,
  input  logic [31:0]        uart_rdata,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);
  typedef enum logic [2:0] {IDLE, POLL, POLL_W, READ, READ_W, TPOLL, TPOLL_W, TWRITE} state_t;
  typedef enum logic [2:0] {HDR, LEN0, LEN1, DATA, CSUM} phase_t;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_LEN = 17'(2 ** IMEM_AW);
  state_t state_q, state_d;
  phase_t phase_q, phase_d;
  logic [16:0] len_q, len_d;
  logic [IMEM_AW:0] widx_q, widx_d;
  logic [31:0] word_q, word_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [7:0] csum_q, csum_d, rx;
  logic [TW-1:0] idle_q, idle_d;
  logic ok_q, ok_d;
  logic uart_cs_q, uart_cs_d, uart_ren_q, uart_ren_d, uart_wen_q, uart_wen_d;
  logic [11:0] uart_addr_q, uart_addr_d;
  logic [31:0] uart_wdata_q, uart_wdata_d;
  logic imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  assign rx = uart_rdata[7:0];
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    len_d = len_q;
    widx_d = widx_q;
    word_d = word_q;
    bcnt_d = bcnt_q;
    csum_d = csum_q;
    ok_d = ok_q;
    idle_d = (phase_q == HDR || idle_q == TW'(TIMEOUT_CYC)) ? idle_q : idle_q + 1'b1;
    imem_we_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = POLL;
        phase_d = HDR;
        widx_d = '0;
        bcnt_d = '0;
        csum_d = '0;
        idle_d = '0;
      end
      POLL: state_d = POLL_W;
      POLL_W: begin
        if (phase_q != HDR && idle_q == TW'(TIMEOUT_CYC)) begin
          ok_d = 1'b0;
          state_d = TPOLL;
        end else state_d = uart_rdata[1] ? POLL : READ;
      end
      READ: state_d = READ_W;
      READ_W: begin
        state_d = POLL;
        idle_d = '0;
        case (phase_q)
          HDR: if (rx == 8'hA5) phase_d = LEN0;
          LEN0: begin
            len_d = {9'd0, rx};
            phase_d = LEN1;
          end
          LEN1: begin
            len_d = {1'b0, rx, len_q[7:0]};
            if (len_d > MAX_LEN) begin
              ok_d = 1'b0;
              state_d = TPOLL;
            end else if (len_d == '0) phase_d = CSUM;
            else phase_d = DATA;
          end
          DATA: begin
            word_d = {rx, word_q[31:8]};
            bcnt_d = bcnt_q + 2'd1;
            csum_d = csum_q + rx;
            if (bcnt_q == 2'd3) begin
              imem_we_d = 1'b1;
              widx_d = widx_q + 1'b1;
              if (17'(widx_d) == len_q) phase_d = CSUM;
            end
          end
          CSUM: begin
            ok_d = rx == csum_q;
            state_d = TPOLL;
          end
          default: phase_d = HDR;
        endcase
      end
      TPOLL: state_d = TPOLL_W;
      TPOLL_W: state_d = uart_rdata[0] ? TPOLL : TWRITE;
      TWRITE: begin
        state_d = IDLE;
        done_d = ok_q;
        err_d = !ok_q;
      end
      default: state_d = IDLE;
    endcase
    uart_cs_d = state_d inside {POLL, READ, TPOLL, TWRITE};
    uart_ren_d = state_d inside {POLL, READ, TPOLL};
    uart_wen_d = state_d == TWRITE;
    uart_addr_d = (state_d == POLL || state_d == TPOLL) ? 12'h004 : 12'h000;
    uart_wdata_d = (state_d == TWRITE) ? {24'h0, ok_d ? ACK_BYTE : NAK_BYTE} : 32'h0;
    imem_addr_d = imem_we_d ? widx_q[IMEM_AW-1:0] : imem_addr_q;
    imem_wdata_d = imem_we_d ? word_d : imem_wdata_q;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= HDR;
      len_q <= '0;
      widx_q <= '0;
      word_q <= '0;
      bcnt_q <= '0;
      csum_q <= '0;
      idle_q <= '0;
      ok_q <= 1'b0;
      uart_cs_q <= 1'b0;
      uart_ren_q <= 1'b0;
      uart_wen_q <= 1'b0;
      uart_addr_q <= '0;
      uart_wdata_q <= '0;
      imem_we_q <= 1'b0;
      imem_addr_q <= '0;
      imem_wdata_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      len_q <= len_d;
      widx_q <= widx_d;
      word_q <= word_d;
      bcnt_q <= bcnt_d;
      csum_q <= csum_d;
      idle_q <= idle_d;
      ok_q <= ok_d;
      uart_cs_q <= uart_cs_d;
      uart_ren_q <= uart_ren_d;
      uart_wen_q <= uart_wen_d;
      uart_addr_q <= uart_addr_d;
      uart_wdata_q <= uart_wdata_d;
      imem_we_q <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign uart_cs = uart_cs_q;
  assign uart_ren = uart_ren_q;
  assign uart_wen = uart_wen_q;
  assign uart_addr = uart_addr_q;
  assign uart_wdata = uart_wdata_q;
  assign imem_we = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign busy = busy_q;
  assign cpu_hold = busy_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: UART/IMEM models around the loader, frame vectors, random frames vs a frame parser model.
module tb_uart_boot_loader;
  localparam int AW = 10;
  localparam int TO = 200;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tx_full = 1'b0;
  logic uart_cs, uart_ren, uart_wen, imem_we, busy, cpu_hold, done, err;
  logic [11:0] uart_addr;
  logic [31:0] uart_wdata, imem_wdata;
  logic [31:0] uart_rdata = '0;
  logic [AW-1:0] imem_addr;
  logic any_out;
  typedef struct {int addr; logic [31:0] data;} wr_t;
  typedef struct {logic [127:0] b; int n; logic ok; int nw; logic [31:0] w0; logic [31:0] w1;} vec_t;
  logic [7:0] rx_buf[$];
  logic [7:0] txq[$];
  wr_t wrq[$];
  logic [7:0] frame[$];
  logic [31:0] exp_w[$];
  logic exp_ok;
  int rd_ptr = 0, done_cnt = 0, err_cnt = 0, bad = 0, cyc = 0;
  logic rx_ok = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
  int n_chk = 0, n_fail = 0;
  vec_t tv[8];

  uart_boot_loader #(.IMEM_AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .uart_cs(uart_cs), .uart_ren(uart_ren), .uart_wen(uart_wen), .uart_addr(uart_addr),
    .uart_wdata(uart_wdata), .uart_rdata(uart_rdata),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  assign any_out = |{uart_cs, uart_ren, uart_wen, uart_addr, uart_wdata, imem_we, imem_addr,
                     imem_wdata, busy, cpu_hold, done, err};

  // UART register model plus bus-rule monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_done <= done;
    prev_err <= err;
    if (uart_cs && uart_ren && uart_addr == 12'h004) begin
      uart_rdata <= {30'd0, rd_ptr >= rx_buf.size(), tx_full};
      rx_ok <= rd_ptr < rx_buf.size();
    end else if (uart_cs && uart_ren && uart_addr == 12'h000) begin
      if (rx_ok && rd_ptr < rx_buf.size()) begin
        uart_rdata <= {24'd0, rx_buf[rd_ptr]};
        rd_ptr <= rd_ptr + 1;
      end else bad <= bad + 1;
      rx_ok <= 1'b0;
    end else if (uart_cs && uart_ren) bad <= bad + 1;
    if ((uart_ren && uart_wen) || ((uart_ren || uart_wen) && !uart_cs) || busy != cpu_hold ||
        (done && err) || ((done || err) && busy) || (done && prev_done) || (err && prev_err) ||
        (imem_we && !busy) || (uart_cs && uart_wen && (tx_full || uart_addr != 12'h000 || uart_wdata[31:8] != '0)))
      bad <= bad + 1;
    if (uart_cs && uart_wen) txq.push_back(uart_wdata[7:0]);
    if (imem_we) wrq.push_back('{int'(imem_addr), imem_wdata});
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Frame parser reference: skip to 0xA5, read LE length, collect LE words, compare byte sum
  task automatic model(input logic [7:0] b[$]);
    int i, len;
    logic [7:0] sum;
    i = 0;
    sum = 8'h00;
    exp_w.delete();
    while (i < b.size() && b[i] != 8'hA5) i++;
    len = int'({b[i+2], b[i+1]});
    i += 3;
    if (len > 2 ** AW) begin
      exp_ok = 1'b0;
      return;
    end
    for (int w = 0; w < len; w++) begin
      exp_w.push_back({b[i+3], b[i+2], b[i+1], b[i]});
      for (int k = 0; k < 4; k++) sum = sum + b[i+k];
      i += 4;
    end
    exp_ok = b[i] == sum;
  endtask

  task automatic gen(input int len, input int njunk, input bit corrupt);
    logic [7:0] s, v;
    s = 8'h00;
    frame.delete();
    repeat (njunk) begin
      v = 8'($urandom);
      frame.push_back(v == 8'hA5 ? 8'h3C : v);
    end
    frame.push_back(8'hA5);
    frame.push_back(8'(len));
    frame.push_back(8'(len >> 8));
    repeat (4 * len) begin
      v = 8'($urandom);
      s = s + v;
      frame.push_back(v);
    end
    frame.push_back(corrupt ? s ^ 8'h5A : s);
  endtask

  task automatic load_vec(input logic [127:0] b, input int n);
    frame.delete();
    for (int k = 0; k < n; k++) frame.push_back(b[8*(n-1-k) +: 8]);
  endtask

  task automatic run(input logic [7:0] b[$], input string nm, input logic ok, input logic [31:0] ew[$]);
    int wb, tb0, d0, e0, t, nbad;
    wb = wrq.size();
    tb0 = txq.size();
    d0 = done_cnt;
    e0 = err_cnt;
    t = 0;
    nbad = 0;
    foreach (b[k]) rx_buf.push_back(b[k]);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (done_cnt == d0 && err_cnt == e0 && t < 8 * b.size() + 200) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " done"}, done_cnt - d0, int'(ok));
    chk({nm, " err"}, err_cnt - e0, int'(!ok));
    chk({nm, " tx count"}, txq.size() - tb0, 1);
    if (txq.size() > tb0) chk({nm, " tx byte"}, int'(txq[tb0]), ok ? 32'h06 : 32'h15);
    chk({nm, " rx left"}, rx_buf.size() - rd_ptr, 0);
    chk({nm, " writes"}, wrq.size() - wb, ew.size());
    foreach (ew[k])
      if (wb + k >= wrq.size() || wrq[wb+k].addr != k || wrq[wb+k].data != ew[k]) nbad++;
    chk({nm, " words"}, nbad, 0);
  endtask

  initial begin
    int t, t0, wb, tb0, d0;
    logic [31:0] ew[$];
    tv[0] = '{96'hA50200112233445566778864, 12, 1'b1, 2, 32'h44332211, 32'h88776655};
    tv[1] = '{96'hA50200112233445566778814, 12, 1'b0, 2, 32'h44332211, 32'h88776655};
    tv[2] = '{80'h00FFA501000100000001, 10, 1'b1, 1, 32'h00000001, 32'h0};
    tv[3] = '{64'hA50100010203040B, 8, 1'b0, 1, 32'h04030201, 32'h0};
    tv[4] = '{32'hA5000000, 4, 1'b1, 0, 32'h0, 32'h0};
    tv[5] = '{32'hA5000001, 4, 1'b0, 0, 32'h0, 32'h0};
    tv[6] = '{24'hA50104, 3, 1'b0, 0, 32'h0, 32'h0};
    tv[7] = '{24'hA5FFFF, 3, 1'b0, 0, 32'h0, 32'h0};
    repeat (3) @(negedge clk);
    chk("reset outputs", int'(any_out), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    foreach (tv[i]) begin
      load_vec(tv[i].b, tv[i].n);
      ew.delete();
      if (tv[i].nw > 0) ew.push_back(tv[i].w0);
      if (tv[i].nw > 1) ew.push_back(tv[i].w1);
      run(frame, $sformatf("vec%0d", i), tv[i].ok, ew);
    end
    for (int r = 0; r < 20; r++) begin
      gen($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      model(frame);
      run(frame, $sformatf("rand%0d", r), exp_ok, exp_w);
    end
    gen(2 ** AW, 0, 1'b0);
    model(frame);
    run(frame, "max len", exp_ok, exp_w);
    // stall after the length: NAK must come once the idle limit is reached, not before
    d0 = err_cnt;
    tb0 = txq.size();
    rx_buf.push_back(8'hA5);
    rx_buf.push_back(8'h02);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t0 = cyc;
    t = 0;
    while (err_cnt == d0 && t < TO + 100) begin
      @(negedge clk);
      t++;
    end
    chk("timeout err", err_cnt - d0, 1);
    chk("timeout not early", int'(cyc - t0 >= TO), 1);
    chk("timeout not late", int'(cyc - t0 <= TO + 40), 1);
    chk("timeout tx", txq.size() > tb0 ? int'(txq[tb0]) : -1, 32'h15);
    // tx_full held: reply and done must wait for release; start while busy is ignored
    tx_full = 1'b1;
    d0 = done_cnt;
    tb0 = txq.size();
    load_vec(32'hA5000000, 4);
    foreach (frame[k]) rx_buf.push_back(frame[k]);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (60) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    chk("txfull no write", txq.size() - tb0, 0);
    chk("txfull no done", done_cnt - d0, 0);
    chk("txfull busy", int'(busy), 1);
    tx_full = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("txfull released done", done_cnt - d0, 1);
    chk("txfull released tx", txq.size() > tb0 ? int'(txq[tb0]) : -1, 32'h06);
    repeat (5) @(negedge clk);
    chk("txfull single session", txq.size() - tb0, 1);
    // reset in the middle of DATA aborts without reply or further writes
    wb = wrq.size();
    tb0 = txq.size();
    load_vec(64'hA502001122334455, 8);
    foreach (frame[k]) rx_buf.push_back(frame[k]);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t = 0;
    while (rd_ptr < rx_buf.size() && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset outputs", int'(any_out), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort writes", wrq.size() - wb, 1);
    chk("abort word", wrq.size() > wb ? int'(wrq[wb].data) : -1, 32'h44332211);
    chk("abort no tx", txq.size() - tb0, 0);
    load_vec(64'hA50100AABBCCDD0E, 8);
    model(frame);
    run(frame, "after reset", exp_ok, exp_w);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst beats start", int'(busy), 0);
    chk("bus rules", bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
